// File: rtl/led_frame_sequencer.sv
// Frame sequencer for the LED image-fetch path: walks one face's pixel addresses,
// waits out the fetch latency, hands GRB words to the serializer, then holds the latch gap.
module led_frame_sequencer #(
  parameter int unsigned TOTAL_LEDS    = 1024,
  parameter int unsigned NUM_FACES     = 8,
  parameter int unsigned FETCH_LATENCY = 4,
  parameter int unsigned LATCH_CYCLES  = 28000,
  localparam int unsigned FACE_W = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1,
  localparam int unsigned ADDR_W = (NUM_FACES * TOTAL_LEDS > 1) ? $clog2(NUM_FACES * TOTAL_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [FACE_W-1:0] face_req,
  input  logic              face_req_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [23:0]       fetch_grb,
  output logic [23:0]       led_data,
  output logic              led_valid,
  input  logic              led_ready,
  output logic [FACE_W-1:0] active_face,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun
);

  localparam int unsigned PIX_W   = (TOTAL_LEDS > 1) ? $clog2(TOTAL_LEDS) : 1;
  localparam int unsigned CNT_MAX = (FETCH_LATENCY > LATCH_CYCLES) ? FETCH_LATENCY : LATCH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic [23:0]       led_data_q, led_data_d;
  logic              led_valid_q, led_valid_d;
  logic [FACE_W-1:0] active_face_q, active_face_d;
  logic [FACE_W-1:0] pending_face_q, pending_face_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_overrun_q, frame_overrun_d;
  logic [FACE_W-1:0] face_raw_c;
  logic [FACE_W-1:0] face_sel_c;

  // A same-cycle request bypasses pending_face; out-of-range faces fall back to face 0.
  always_comb begin
    face_raw_c = face_req_valid ? face_req : pending_face_q;
    face_sel_c = face_raw_c;
    if (32'(face_raw_c) >= NUM_FACES) begin
      face_sel_c = '0;
    end
  end

  always_comb begin
    state_d         = state_q;
    pixel_d         = pixel_q;
    cnt_d           = cnt_q;
    pixel_addr_d    = pixel_addr_q;
    led_data_d      = led_data_q;
    led_valid_d     = led_valid_q;
    active_face_d   = active_face_q;
    pending_face_d  = face_req_valid ? face_req : pending_face_q;
    frame_overrun_d = frame_start && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          active_face_d = face_sel_c;
          pixel_d       = '0;
          pixel_addr_d  = ADDR_W'(32'(face_sel_c) * TOTAL_LEDS);
          cnt_d         = '0;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Address has been stable for FETCH_LATENCY cycles on the final edge.
        if (cnt_q == CNT_W'(FETCH_LATENCY)) begin
          led_data_d  = fetch_grb;
          led_valid_d = 1'b1;
          state_d     = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (led_valid_q && led_ready) begin
          led_valid_d = 1'b0;
          cnt_d       = '0;
          if (pixel_q == PIX_W'(TOTAL_LEDS - 1)) begin
            state_d = ST_LATCH;
          end else begin
            pixel_d      = pixel_q + PIX_W'(1);
            pixel_addr_d = pixel_addr_q + ADDR_W'(1);
            state_d      = ST_FETCH;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    // frame_done is high during the last LATCH cycle, while still busy.
    frame_done_d = (state_d == ST_LATCH) && (cnt_d == CNT_W'(LATCH_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      pixel_q         <= '0;
      cnt_q           <= '0;
      pixel_addr_q    <= '0;
      led_data_q      <= '0;
      led_valid_q     <= 1'b0;
      active_face_q   <= '0;
      pending_face_q  <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pixel_q         <= pixel_d;
      cnt_q           <= cnt_d;
      pixel_addr_q    <= pixel_addr_d;
      led_data_q      <= led_data_d;
      led_valid_q     <= led_valid_d;
      active_face_q   <= active_face_d;
      pending_face_q  <= pending_face_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign pixel_addr    = pixel_addr_q;
  assign led_data      = led_data_q;
  assign led_valid     = led_valid_q;
  assign active_face   = active_face_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: two instances (8 and 6 faces) share stimulus and are
// compared every cycle against a timestamp-based frame model.
module tb_led_frame_sequencer;

  localparam int unsigned T  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned LC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        face_req_valid;
  logic [2:0]  face_req;
  logic        led_ready;
  logic [4:0]  pa   [2];
  logic [23:0] grb  [2];
  logic [23:0] ld   [2];
  logic        lv   [2];
  logic [2:0]  af   [2];
  logic        bsy  [2];
  logic        fd   [2];
  logic        fo   [2];
  logic [23:0] pipe [2][L];

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  // Model state: frame in progress, face, pixel, cycle of next valid, cycle of frame_done.
  int m_in [2], m_face [2], m_pend [2], m_pix [2], m_valid_at [2], m_done_at [2], m_data [2];
  bit m_ovr [2], m_ev [2];

  always #5 clk = ~clk;

  led_frame_sequencer #(.TOTAL_LEDS(T), .NUM_FACES(8), .FETCH_LATENCY(L), .LATCH_CYCLES(LC)) u_dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .face_req(face_req),
    .face_req_valid(face_req_valid), .pixel_addr(pa[0]), .fetch_grb(grb[0]),
    .led_data(ld[0]), .led_valid(lv[0]), .led_ready(led_ready), .active_face(af[0]),
    .busy(bsy[0]), .frame_done(fd[0]), .frame_overrun(fo[0])
  );

  led_frame_sequencer #(.TOTAL_LEDS(T), .NUM_FACES(6), .FETCH_LATENCY(L), .LATCH_CYCLES(LC)) u_dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .face_req(face_req),
    .face_req_valid(face_req_valid), .pixel_addr(pa[1]), .fetch_grb(grb[1]),
    .led_data(ld[1]), .led_valid(lv[1]), .led_ready(led_ready), .active_face(af[1]),
    .busy(bsy[1]), .frame_done(fd[1]), .frame_overrun(fo[1])
  );

  // Fetch pipeline stand-in: GRB = address + 0x100, delayed by exactly L cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < int'(L); s++) begin
        if (s == 0) pipe[i][0] <= 24'(pa[i]) + 24'h100;
        else        pipe[i][s] <= pipe[i][s-1];
      end
    end
  end
  assign grb[0] = pipe[0][L-1];
  assign grb[1] = pipe[1][L-1];

  function automatic int nf(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 0; m_face[i] = 0; m_pend[i] = 0; m_pix[i] = 0; m_data[i] = 0;
      m_valid_at[i] = -1; m_done_at[i] = -1; m_ovr[i] = 1'b0; m_ev[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      m_ev[i] = (m_in[i] != 0) && (m_valid_at[i] >= 0) && (k >= m_valid_at[i]);
      if (m_ev[i]) m_data[i] = m_face[i] * int'(T) + m_pix[i] + 'h100;
      check_eq($sformatf("d%0d_busy", i),     int'(bsy[i]), m_in[i]);
      check_eq($sformatf("d%0d_valid", i),    int'(lv[i]),  int'(m_ev[i]));
      check_eq($sformatf("d%0d_data", i),     int'(ld[i]),  m_data[i]);
      check_eq($sformatf("d%0d_addr", i),     int'(pa[i]),  m_face[i] * int'(T) + m_pix[i]);
      check_eq($sformatf("d%0d_face", i),     int'(af[i]),  m_face[i]);
      check_eq($sformatf("d%0d_done", i),     int'(fd[i]),  int'(m_in[i] != 0 && k == m_done_at[i]));
      check_eq($sformatf("d%0d_overrun", i),  int'(fo[i]),  int'(m_ovr[i]));
    end
  endtask

  task automatic step_model(input bit fs, input bit frv, input int fr, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      bit was_busy;
      int sel;
      was_busy = (m_in[i] != 0);
      m_ovr[i] = fs && was_busy;
      if (m_ev[i] && rdy) begin
        if (m_pix[i] == int'(T) - 1) begin
          m_valid_at[i] = -1;
          m_done_at[i]  = k + int'(LC);
        end else begin
          m_pix[i]++;
          m_valid_at[i] = k + int'(L) + 2;
        end
      end
      if (was_busy && k == m_done_at[i]) m_in[i] = 0;
      if (fs && !was_busy) begin
        sel = frv ? fr : m_pend[i];
        if (sel >= nf(i)) sel = 0;
        m_face[i] = sel; m_pix[i] = 0; m_in[i] = 1;
        m_valid_at[i] = k + int'(L) + 2;
        m_done_at[i]  = -1;
      end
      if (frv) m_pend[i] = fr;
    end
  endtask

  // Apply inputs for the current cycle, advance one clock, check the new cycle.
  task automatic drive_cycle(input bit fs, input bit frv, input int fr, input bit rdy);
    frame_start = fs; face_req_valid = frv; face_req = 3'(fr); led_ready = rdy;
    if (rst) step_model(fs, frv, fr, rdy);
    else     reset_model();
    @(posedge clk);
    #1;
    k++;
    check_all();
  endtask

  task automatic run_until_idle();
    for (int n = 0; n < 400 && m_in[0] != 0; n++) drive_cycle(1'b0, 1'b0, 0, 1'b1);
    check_eq("frame_completes", int'(bsy[0]), 0);
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; face_req_valid = 1'b0; face_req = '0; led_ready = 1'b0;
    reset_model();
    #1;
    check_all();
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0, 0, 1'b1);

    // Basic frame on face 0
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    run_until_idle();
    check_eq("basic_last_addr", int'(pa[0]), 3);
    drive_cycle(1'b0, 1'b0, 0, 1'b1);

    // Face select, then a mid-frame request that must not disturb the running frame
    drive_cycle(1'b0, 1'b1, 5, 1'b1);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    repeat (8) drive_cycle(1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b0, 1'b1, 7, 1'b1);
    check_eq("face_held_mid_frame", int'(af[0]), 5);
    run_until_idle();
    check_eq("face5_last_addr", int'(pa[0]), 23);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    run_until_idle();
    check_eq("face7_active", int'(af[0]), 7);
    check_eq("face7_last_addr", int'(pa[0]), 31);
    check_eq("oor_face_forced_zero", int'(af[1]), 0);
    check_eq("oor_last_addr", int'(pa[1]), 3);

    // Backpressure on pixel 2
    drive_cycle(1'b1, 1'b1, 0, 1'b1);
    for (int n = 0; n < 100 && !(m_ev[0] && m_pix[0] == 2); n++) drive_cycle(1'b0, 1'b0, 0, 1'b1);
    repeat (7) drive_cycle(1'b0, 1'b0, 0, 1'b0);
    check_eq("bp_addr_held", int'(pa[0]), 2);
    check_eq("bp_data_held", int'(ld[0]), 'h102);
    run_until_idle();

    // Overrun during FETCH, mid-LATCH, and on the frame_done cycle
    drive_cycle(1'b1, 1'b1, 3, 1'b1);
    drive_cycle(1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    check_eq("overrun_fetch", int'(fo[0]), 1);
    for (int n = 0; n < 200 && !(m_done_at[0] >= 0 && k >= m_done_at[0] - 4); n++)
      drive_cycle(1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    for (int n = 0; n < 20 && k < m_done_at[0]; n++) drive_cycle(1'b0, 1'b0, 0, 1'b1);
    check_eq("done_cycle_reached", int'(fd[0]), 1);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    check_eq("overrun_on_done", int'(fo[0]), 1);
    check_eq("idle_after_done", int'(bsy[0]), 0);
    run_until_idle();

    // Asynchronous reset while pixel 1 is being offered
    drive_cycle(1'b1, 1'b1, 2, 1'b1);
    for (int n = 0; n < 100 && !(m_ev[0] && m_pix[0] == 1); n++) drive_cycle(1'b0, 1'b0, 0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    reset_model();
    check_all();
    drive_cycle(1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b0, 1'b0, 0, 1'b1);
    rst = 1'b1;
    drive_cycle(1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    check_eq("post_reset_addr", int'(pa[0]), 0);
    run_until_idle();

    // Randomized traffic
    for (int n = 0; n < 2500; n++)
      drive_cycle(($urandom % 16) == 0, ($urandom % 4) == 0, int'($urandom % 8), ($urandom % 4) != 0);
    run_until_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
